dram_ref_reader: RTL and testbench



---
 rtl/dram_ref_reader.sv | 147 ++++++++++++++
 tb/tb_dram_ref_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ref_reader.sv
// Streams reference blocks from DRAM through a credit-limited return FIFO.
// Optional stall counter port is enabled with macro DRAM_REF_READER_PERF_EN.
module dram_ref_reader #(
  parameter int REF_LENGTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [24:0]             ref_addr_in,
  input  logic [24:0]             ref_length_in,
  input  logic                    ref_info_valid_in,
  output logic [24:0]             dram_cmd_addr_out,
  output logic                    dram_cmd_valid_out,
  input  logic                    dram_cmd_rdy_in,
  input  logic [2*REF_LENGTH-1:0] dram_rd_data_in,
  input  logic                    dram_rd_valid_in,
  output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
  output logic                    ref_seq_block_valid_out,
  input  logic                    ref_seq_block_rdy_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    overrun_out
`ifdef DRAM_REF_READER_PERF_EN
  ,
  output logic [31:0]             stall_cycles_out
`endif
);

  // state | meaning
  // IDLE  | waiting for a request
  // ISSUE | read commands still to be sent
  // DRAIN | all commands sent, waiting for the last block to be consumed
  localparam int W  = 2 * REF_LENGTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [24:0]    cmd_addr;
  logic [24:0]    cmds_left;
  logic [24:0]    blocks_left;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [W-1:0]   mem [FIFO_DEPTH];
  logic           done_zero;
  logic           overrun;
  logic           accept;
  logic           cmd_xfer;
  logic           push;
  logic           pop;
  logic           last_pop;
  logic [CW:0]    credit_used;

  always_comb begin
    accept                  = (state == IDLE) && ref_info_valid_in;
    credit_used             = {1'b0, outstanding} + {1'b0, fifo_count};
    // Blocks in flight plus blocks buffered never exceed the FIFO depth.
    dram_cmd_valid_out      = (state == ISSUE) && (cmds_left != 25'd0) &&
                              (credit_used < (CW+1)'(FIFO_DEPTH));
    cmd_xfer                = dram_cmd_valid_out && dram_cmd_rdy_in;
    push                    = dram_rd_valid_in && (outstanding != '0);
    ref_seq_block_valid_out = (fifo_count != '0);
    pop                     = ref_seq_block_valid_out && ref_seq_block_rdy_in;
    last_pop                = (state == DRAIN) && pop && (blocks_left == 25'd1);
    dram_cmd_addr_out       = cmd_addr;
    ref_seq_block_out       = ref_seq_block_valid_out ? mem[rd_ptr] : '0;
    busy_out                = (state != IDLE);
    done_out                = done_zero || last_pop;
    overrun_out             = overrun;
    state_nxt               = state;
    case (state)
      IDLE:    if (accept && (ref_length_in != 25'd0)) state_nxt = ISSUE;
      ISSUE:   if (cmd_xfer && (cmds_left == 25'd1)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_addr    <= '0;
      cmds_left   <= '0;
      blocks_left <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      done_zero   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_zero <= accept && (ref_length_in == 25'd0);
      if (ref_info_valid_in && (state != IDLE)) overrun <= 1'b1;

      if (accept) begin
        cmd_addr    <= ref_addr_in;
        cmds_left   <= ref_length_in;
        blocks_left <= ref_length_in;
      end else begin
        if (cmd_xfer) begin
          cmd_addr  <= cmd_addr + 25'd1;
          cmds_left <= cmds_left - 25'd1;
        end
        if (pop) blocks_left <= blocks_left - 25'd1;
      end

      case ({cmd_xfer, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= dram_rd_data_in;
  end

`ifdef DRAM_REF_READER_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      stall_cnt <= '0;
    end else if (ref_seq_block_valid_out && !ref_seq_block_rdy_in &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_out = stall_cnt;
`endif

endmodule

// File: tb/tb_dram_ref_reader.sv
// Directed and randomized bench for dram_ref_reader with a DRAM responder model
// and a scoreboard derived from the request (address sequence, data, credit limit).
module tb_dram_ref_reader;
  localparam int RL    = 16;
  localparam int W     = 2 * RL;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [24:0]   ref_addr = '0;
  logic [24:0]   ref_len = '0;
  logic          ref_valid = 1'b0;
  logic [24:0]   cmd_addr;
  logic          cmd_valid;
  logic          dram_rdy = 1'b1;
  logic [W-1:0]  rd_data = '0;
  logic          rd_valid = 1'b0;
  logic [W-1:0]  blk_out;
  logic          blk_valid;
  logic          eng_rdy = 1'b1;
  logic          busy;
  logic          done;
  logic          overrun;
`ifdef DRAM_REF_READER_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  dram_ref_reader #(.REF_LENGTH(RL), .FIFO_DEPTH(DEPTH)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .ref_addr_in             (ref_addr),
    .ref_length_in           (ref_len),
    .ref_info_valid_in       (ref_valid),
    .dram_cmd_addr_out       (cmd_addr),
    .dram_cmd_valid_out      (cmd_valid),
    .dram_cmd_rdy_in         (dram_rdy),
    .dram_rd_data_in         (rd_data),
    .dram_rd_valid_in        (rd_valid),
    .ref_seq_block_out       (blk_out),
    .ref_seq_block_valid_out (blk_valid),
    .ref_seq_block_rdy_in    (eng_rdy),
    .busy_out                (busy),
    .done_out                (done),
    .overrun_out             (overrun)
`ifdef DRAM_REF_READER_PERF_EN
    ,
    .stall_cycles_out        (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    int          due;
  } pend_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            lat = 2;
  bit            rand_mode = 0;
  bit            dram_rdy_fix = 1;
  bit            eng_rdy_fix = 1;
  pend_t         pend_q[$];
  logic [24:0]   exp_cmd_q[$];
  logic [W-1:0]  exp_dat_q[$];
  int            cmd_cyc_q[$];
  int            blk_cyc_q[$];
  int            inflight = 0;
  int            n_cmds = 0;
  int            n_pops = 0;
  int            done_cnt = 0;
  int            req_cyc = 0;
  bit            prev_cmd_hold = 0;
  logic [24:0]   prev_cmd_addr = '0;
  bit            prev_blk_hold = 0;
  logic [W-1:0]  prev_blk = '0;

  function automatic logic [W-1:0] blk_of(input logic [24:0] a);
    return {a[6:0], a} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DRAM responder: returns each accepted command's block 'lat' cycles later.
  always @(posedge clk) begin
    #1;
    cyc++;
    rd_valid = 1'b0;
    rd_data  = '0;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rd_valid = 1'b1;
      rd_data  = blk_of(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
    dram_rdy = rand_mode ? ($urandom_range(0, 3) != 0) : dram_rdy_fix;
    eng_rdy  = rand_mode ? ($urandom_range(0, 2) != 0) : eng_rdy_fix;
  end

  // Protocol and scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (prev_cmd_hold) begin
        check("cmd_hold_valid", cmd_valid, 1);
        check("cmd_hold_addr", cmd_addr, prev_cmd_addr);
      end
      if (prev_blk_hold) begin
        check("blk_hold_valid", blk_valid, 1);
        check("blk_hold_data", blk_out, prev_blk);
      end
      if (busy) check("credit_valid", cmd_valid, (exp_cmd_q.size() > 0) && (inflight < DEPTH));
      if (cmd_valid && dram_rdy) begin
        check("cmd_expected", exp_cmd_q.size() > 0, 1);
        if (exp_cmd_q.size() > 0) check("cmd_addr", cmd_addr, exp_cmd_q.pop_front());
        pend_q.push_back('{cmd_addr, cyc + lat});
        inflight++;
        n_cmds++;
        cmd_cyc_q.push_back(cyc);
      end
      if (blk_valid && eng_rdy) begin
        check("blk_expected", exp_dat_q.size() > 0, 1);
        if (exp_dat_q.size() > 0) check("blk_data", blk_out, exp_dat_q.pop_front());
        inflight--;
        n_pops++;
        blk_cyc_q.push_back(cyc);
      end
      prev_cmd_hold = cmd_valid && !dram_rdy;
      prev_cmd_addr = cmd_addr;
      prev_blk_hold = blk_valid && !eng_rdy;
      prev_blk      = blk_out;
    end else begin
      prev_cmd_hold = 0;
      prev_blk_hold = 0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cmd_q.delete();
    exp_dat_q.delete();
    inflight = 0;
  endtask

  task automatic request(input logic [24:0] a, input logic [24:0] n, input bit model);
    if (model) begin
      for (int i = 0; i < int'(n); i++) begin
        logic [24:0] ai;
        ai = 25'((int'(a) + i) % (1 << 25));
        exp_cmd_q.push_back(ai);
        exp_dat_q.push_back(blk_of(ai));
      end
    end
    ref_addr  = a;
    ref_len   = n;
    ref_valid = 1'b1;
    @(negedge clk);
    req_cyc = cyc;
    @(posedge clk);
    #1;
    ref_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((busy || exp_dat_q.size() > 0) && k < budget) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, k < budget, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, p0, d0;
    logic [24:0] ra;
    logic [24:0] rn;

    step(3);
    @(negedge clk);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_out", blk_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    step();
    rst = 1'b0;

    // Basic three-block request, DRAM latency 2, engine always ready.
    lat = 2;
    cmd_cyc_q.delete();
    blk_cyc_q.delete();
    c0 = n_cmds; d0 = done_cnt;
    request(25'h100, 25'd3, 1);
    @(negedge clk);
    check("s1_first_valid", cmd_valid, 1);
    check("s1_first_addr", cmd_addr, 25'h100);
    check("s1_busy", busy, 1);
    wait_idle("s1", 100);
    step(2);
    check("s1_ncmd", n_cmds - c0, 3);
    check("s1_first_cyc", cmd_cyc_q[0], req_cyc + 1);
    check("s1_consecutive", cmd_cyc_q[2] - cmd_cyc_q[0], 2);
    check("s1_first_blk_cyc", blk_cyc_q[0], req_cyc + 4);
    check("s1_done", done_cnt - d0, 1);

    // Engine stalled: credit limits issue to the FIFO depth.
    eng_rdy_fix = 0;
    c0 = n_cmds; p0 = n_pops; d0 = done_cnt;
    request(25'h2000, 25'd8, 1);
    step(20);
    check("s2_stalled_ncmd", n_cmds - c0, DEPTH);
    check("s2_stalled_valid", cmd_valid, 0);
    eng_rdy_fix = 1;
    wait_idle("s2", 200);
    step(2);
    check("s2_ncmd", n_cmds - c0, 8);
    check("s2_npop", n_pops - p0, 8);
    check("s2_done", done_cnt - d0, 1);

    // Zero-length request.
    c0 = n_cmds; d0 = done_cnt;
    request(25'h55, 25'd0, 1);
    @(negedge clk);
    check("s3_done_pulse", done, 1);
    check("s3_busy", busy, 0);
    check("s3_cmd_valid", cmd_valid, 0);
    step();
    @(negedge clk);
    check("s3_done_low", done, 0);
    check("s3_busy2", busy, 0);
    step(3);
    check("s3_ncmd", n_cmds - c0, 0);
    check("s3_done_cnt", done_cnt - d0, 1);

    // Second request while busy is ignored and flagged.
    c0 = n_cmds; d0 = done_cnt;
    request(25'h300, 25'd5, 1);
    step();
    request(25'h777, 25'd2, 0);
    @(negedge clk);
    check("s4_overrun", overrun, 1);
    wait_idle("s4", 200);
    step(2);
    check("s4_ncmd", n_cmds - c0, 5);
    check("s4_done", done_cnt - d0, 1);
    check("s4_overrun_sticky", overrun, 1);

    // Reset mid-drain with returns still outstanding.
    do_reset();
    lat = 8;
    d0 = done_cnt;
    request(25'h400, 25'd2, 1);
    step(3);
    check("s5_in_drain", busy, 1);
    do_reset();
    @(negedge clk);
    check("s5_busy", busy, 0);
    check("s5_cmd_valid", cmd_valid, 0);
    check("s5_cmd_addr", cmd_addr, 0);
    check("s5_blk_out", blk_out, 0);
    check("s5_overrun", overrun, 0);
    check("s5_done", done, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      @(negedge clk);
      check("s5_no_blk", blk_valid, 0);
    end
    check("s5_done_cnt", done_cnt - d0, 0);

    // Address wrap at the top of the 25-bit space.
    lat = 2;
    step();
    c0 = n_cmds;
    request(25'h1FF_FFFE, 25'd3, 1);
    wait_idle("s6", 100);
    check("s6_ncmd", n_cmds - c0, 3);

    // Randomized requests with random latency and back-pressure on both sides.
    rand_mode = 1;
    for (int t = 0; t < 8; t++) begin
      lat = $urandom_range(1, 5);
      ra  = ($urandom_range(0, 3) == 0) ? 25'h1FF_FFF8 + 25'($urandom_range(0, 7))
                                        : 25'($urandom);
      rn  = 25'($urandom_range(1, 12));
      c0 = n_cmds; d0 = done_cnt;
      request(ra, rn, 1);
      wait_idle("rand", 600);
      step(2);
      check("rand_ncmd", n_cmds - c0, rn);
      check("rand_done", done_cnt - d0, 1);
    end
    rand_mode = 0;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
